// File: rtl/usb_tx_sched_pkg.sv
// Shared types, field widths and helpers for the USB full-speed TX bit scheduler.
package usb_tx_sched_pkg;

  localparam int unsigned SYNC_BITS  = 8;
  localparam int unsigned PID_BITS   = 8;
  localparam int unsigned CRC16_BITS = 16;
  localparam int unsigned EOP_BITS   = 3;
  localparam int unsigned TOKEN_BITS = 32;
  localparam int unsigned HS_BITS    = 16;

  typedef enum logic [1:0] {
    PKT_TOKEN     = 2'd0,
    PKT_DATA      = 2'd1,
    PKT_HANDSHAKE = 2'd2,
    PKT_RSVD      = 2'd3
  } pkt_kind_t;

  typedef enum logic [2:0] {
    FLD_IDLE    = 3'd0,
    FLD_SYNC    = 3'd1,
    FLD_PID     = 3'd2,
    FLD_PAYLOAD = 3'd3,
    FLD_CRC     = 3'd4,
    FLD_EOP     = 3'd5
  } field_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_EOP  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  // Packet length in bits, SYNC through CRC, with the DATA payload clamped.
  function automatic int unsigned total_bits(pkt_kind_t kind, logic [6:0] len,
                                             int unsigned max_bytes);
    int unsigned l;
    int unsigned t;
    l = 32'(len);
    if (l > max_bytes) l = max_bytes;
    case (kind)
      PKT_TOKEN: t = TOKEN_BITS;
      PKT_DATA:  t = (l + 4) * 8;
      default:   t = HS_BITS;
    endcase
    return t;
  endfunction

  // Field of the bit currently on the wire. TOKEN address/endp/crc5 go out as payload.
  function automatic field_t field_of(state_t st, pkt_kind_t kind, int unsigned idx,
                                      int unsigned total);
    field_t f;
    f = FLD_IDLE;
    case (st)
      ST_SEND: begin
        if (idx < SYNC_BITS)
          f = FLD_SYNC;
        else if (kind == PKT_HANDSHAKE || idx < SYNC_BITS + PID_BITS)
          f = FLD_PID;
        else if (kind == PKT_DATA && idx + CRC16_BITS >= total)
          f = FLD_CRC;
        else
          f = FLD_PAYLOAD;
      end
      ST_EOP:  f = FLD_EOP;
      default: f = FLD_IDLE;
    endcase
    return f;
  endfunction

endpackage

// File: rtl/usb_tx_bit_div.sv
// Bit-period divider: counts 0..CLKS_PER_BIT-1 and flags the last clock of each period.
module usb_tx_bit_div #(
  parameter int CLKS_PER_BIT = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  output logic tick_o
);

  localparam int W = $clog2(CLKS_PER_BIT);

  logic [W-1:0] r_cnt;

  assign tick_o = (r_cnt == W'(CLKS_PER_BIT - 1));

  // Free-running period counter, held at zero while cleared.
  always_ff @(posedge clk) begin
    if (rst || clr_i)
      r_cnt <= '0;
    else if (tick_o)
      r_cnt <= '0;
    else
      r_cnt <= r_cnt + 1'b1;
  end

endmodule

// File: rtl/usb_tx_bit_scheduler.sv
// USB full-speed TX bit scheduler: paces bit periods, tracks the bit index of one
// packet and reports which field is on the wire.
// Optional feature macro: USB_TX_SCHED_STUFF_EN (stuff bits stretch the packet).
//
//  state | meaning
//  IDLE  | waiting for start_i, ready_o=1
//  SEND  | shifting SYNC..CRC, bit_idx advances on each non-stuff tick
//  EOP   | three end-of-packet periods (SE0, SE0, J)
//  DONE  | single cycle, done_o pulses, then back to IDLE
//
// All state changes act on the registered tick, so bit_idx_o/field_o still show the
// bit that is ending while bit_tick_o is high.
module usb_tx_bit_scheduler
  import usb_tx_sched_pkg::*;
#(
  parameter int CLKS_PER_BIT   = 8,
  parameter int MAX_DATA_BYTES = 64,
  parameter int CNT_W          = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [1:0]       pkt_kind_i,
  input  logic [6:0]       data_len_i,
  input  logic             abort_i,
  input  logic             stuff_i,
  output logic             ready_o,
  output logic             bit_tick_o,
  output logic             byte_tick_o,
  output logic [CNT_W-1:0] bit_idx_o,
  output logic [2:0]       field_o,
  output logic             done_o
);

  state_t           r_state;
  pkt_kind_t        r_kind;
  logic [CNT_W-1:0] r_idx;
  logic [CNT_W-1:0] r_total;
  logic [1:0]       r_eop_cnt;
  logic             r_bit_tick;
  logic             r_ready;
  logic             r_done;

  logic             w_div_tick;
  logic             w_div_clr;
  logic             w_stuff;
  pkt_kind_t        w_kind;
  field_t           w_field;

`ifdef USB_TX_SCHED_STUFF_EN
  assign w_stuff = stuff_i;
`else
  logic w_unused_stuff;
  assign w_unused_stuff = stuff_i;
  assign w_stuff        = 1'b0;
`endif

  // Reserved kind behaves like a handshake.
  assign w_kind = (pkt_kind_t'(pkt_kind_i) == PKT_RSVD) ? PKT_HANDSHAKE
                                                        : pkt_kind_t'(pkt_kind_i);

  // Divider runs only while a packet is on the wire; abort restarts it immediately.
  assign w_div_clr = !(r_state == ST_SEND || r_state == ST_EOP) || abort_i;

  usb_tx_bit_div #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_div (
    .clk   (clk),
    .rst   (rst),
    .clr_i (w_div_clr),
    .tick_o(w_div_tick)
  );

  // Packet sequencing, bit index and EOP period counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_kind     <= PKT_TOKEN;
      r_idx      <= '0;
      r_total    <= '0;
      r_eop_cnt  <= '0;
      r_bit_tick <= 1'b0;
      r_ready    <= 1'b1;
      r_done     <= 1'b0;
    end else begin
      r_bit_tick <= 1'b0;
      r_done     <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start_i) begin
            r_state <= ST_SEND;
            r_ready <= 1'b0;
            r_idx   <= '0;
            r_kind  <= w_kind;
            r_total <= CNT_W'(total_bits(w_kind, data_len_i, MAX_DATA_BYTES));
          end
        end
        ST_SEND: begin
          if (abort_i) begin
            r_state <= ST_IDLE;
            r_ready <= 1'b1;
            r_idx   <= '0;
          end else begin
            r_bit_tick <= w_div_tick;
            if (r_bit_tick && !w_stuff) begin
              if (r_idx == r_total - 1'b1) begin
                r_state   <= ST_EOP;
                r_eop_cnt <= 2'(EOP_BITS - 1);
              end else begin
                r_idx <= r_idx + 1'b1;
              end
            end
          end
        end
        ST_EOP: begin
          if (abort_i) begin
            r_state <= ST_IDLE;
            r_ready <= 1'b1;
            r_idx   <= '0;
          end else begin
            r_bit_tick <= w_div_tick;
            if (r_bit_tick) begin
              if (r_eop_cnt == 2'd0) begin
                r_state <= ST_DONE;
                r_done  <= 1'b1;
              end else begin
                r_eop_cnt <= r_eop_cnt - 1'b1;
              end
            end
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_ready <= 1'b1;
          r_idx   <= '0;
        end
      endcase
    end
  end

  assign w_field = field_of(r_state, r_kind, 32'(r_idx), 32'(r_total));

  assign ready_o     = r_ready;
  assign bit_tick_o  = r_bit_tick;
  assign byte_tick_o = r_bit_tick && (r_state == ST_SEND) && (r_idx[2:0] == 3'd7) && !w_stuff;
  assign bit_idx_o   = r_idx;
  assign field_o     = w_field;
  assign done_o      = r_done;

endmodule
